// File: rtl/acc_requant_drain.sv
// Captures one row of NUM_COLS accumulators and drains it one requantised element per
// accepted cycle. Define REQUANT_ROUND_EN to add round-half-up ahead of the shift.
module acc_requant_drain #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned NUM_COLS   = 4,
    parameter int unsigned SHIFT_W    = $clog2(ACC_WIDTH),
    localparam int unsigned COL_W     = $clog2(NUM_COLS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [SHIFT_W-1:0]            shift_i,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    input  logic [NUM_COLS*ACC_WIDTH-1:0] row_acc_i,
    input  logic                          row_last_i,
    output logic                          z_valid_o,
    input  logic                          z_ready_i,
    output logic [DATA_WIDTH-1:0]         z_o,
    output logic [COL_W-1:0]              col_idx_o,
    output logic                          z_last_o,
    output logic                          sat_o,
    input  logic                          clr_sat_i
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    localparam logic [DATA_WIDTH-1:0] ZMax = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ZMin = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                        state_q, state_d;
    logic [COL_W-1:0]              col_q, col_d;
    logic [NUM_COLS*ACC_WIDTH-1:0] buf_q, buf_d;
    logic [SHIFT_W-1:0]            shift_q, shift_d;
    logic                          last_q, last_d;
    logic                          sat_q, sat_d;

    logic                          capture, accept, col_end;
    logic signed [ACC_WIDTH-1:0]   elem;
    logic signed [ACC_WIDTH:0]     ext, t;
    logic                          sat_hi, sat_lo;
    logic [DATA_WIDTH-1:0]         z_sat;

    assign col_end = (col_q == COL_W'(NUM_COLS - 1));
    assign capture = (state_q == StIdle) && row_valid_i;
    assign accept  = (state_q == StDrain) && z_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            col_q   <= '0;
            buf_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            sat_q   <= sat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        buf_d   = buf_q;
        shift_d = shift_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    buf_d   = row_acc_i;
                    shift_d = shift_i;
                    last_d  = row_last_i;
                    col_d   = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (accept) begin
                    if (col_end) begin
                        state_d = StIdle;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Requantisation datapath; one extra bit keeps the rounding add from wrapping.
    always_comb begin
        elem = buf_q[col_q*ACC_WIDTH +: ACC_WIDTH];
        ext  = {elem[ACC_WIDTH-1], elem};
`ifdef REQUANT_ROUND_EN
        begin
            logic signed [ACC_WIDTH:0] rnd;
            logic signed [ACC_WIDTH:0] sum;
            rnd = '0;
            if (shift_q != '0) begin
                rnd = (ACC_WIDTH+1)'(1) << (shift_q - 1'b1);
            end
            sum = ext + rnd;
            t   = sum >>> shift_q;
        end
`else
        t = ext >>> shift_q;
`endif
        sat_hi = !t[ACC_WIDTH] && (|t[ACC_WIDTH-1:DATA_WIDTH-1]);
        sat_lo = t[ACC_WIDTH] && !(&t[ACC_WIDTH-1:DATA_WIDTH-1]);
        if (sat_hi) begin
            z_sat = ZMax;
        end else if (sat_lo) begin
            z_sat = ZMin;
        end else begin
            z_sat = t[DATA_WIDTH-1:0];
        end
    end

    // Sticky saturation flag: a saturating accept beats a same-cycle clear.
    always_comb begin
        sat_d = sat_q;
        if (clr_sat_i) begin
            sat_d = 1'b0;
        end
        if (accept && (sat_hi || sat_lo)) begin
            sat_d = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        row_ready_o = 1'b0;
        z_valid_o   = 1'b0;
        z_o         = '0;
        col_idx_o   = '0;
        z_last_o    = 1'b0;
        unique case (state_q)
            StIdle: begin
                row_ready_o = 1'b1;
            end
            StDrain: begin
                z_valid_o = 1'b1;
                z_o       = z_sat;
                col_idx_o = col_q;
                z_last_o  = last_q && col_end;
            end
            default: begin
                row_ready_o = 1'b0;
            end
        endcase
    end

    assign sat_o = sat_q;

endmodule

// File: tb/tb_acc_requant_drain.sv
// Randomised bench for acc_requant_drain; a queue of expected elements is filled at each
// row capture from plain integer requantisation and checked every cycle.
module tb_acc_requant_drain;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int NC = 4;
    localparam int SW = $clog2(AW);
    localparam int CW = $clog2(NC);

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [SW-1:0]     shift_i = '0;
    logic              row_valid_i = 1'b0;
    logic              row_ready_o;
    logic [NC*AW-1:0]  row_acc_i = '0;
    logic              row_last_i = 1'b0;
    logic              z_valid_o;
    logic              z_ready_i = 1'b0;
    logic [DW-1:0]     z_o;
    logic [CW-1:0]     col_idx_o;
    logic              z_last_o;
    logic              sat_o;
    logic              clr_sat_i = 1'b0;

    acc_requant_drain #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .NUM_COLS   (NC)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .shift_i     (shift_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .row_acc_i   (row_acc_i),
        .row_last_i  (row_last_i),
        .z_valid_o   (z_valid_o),
        .z_ready_i   (z_ready_i),
        .z_o         (z_o),
        .col_idx_o   (col_idx_o),
        .z_last_o    (z_last_o),
        .sat_o       (sat_o),
        .clr_sat_i   (clr_sat_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] z;
        int            col;
        bit            last;
        bit            sat;
    } elem_t;

    elem_t exp_q[$];
    bit    sat_exp;
    int    n_chk;
    int    n_pass;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Reference requantisation: floor shift (optionally round-half-up), then clamp.
    function automatic logic [DW:0] requant(input logic [AW-1:0] acc, input int sh);
        longint a;
        logic   s;
        a = longint'($signed(acc));
`ifdef REQUANT_ROUND_EN
        if (sh > 0) a = a + (longint'(1) << (sh - 1));
`endif
        a = a >>> sh;
        s = 1'b0;
        if (a > 32767) begin a = 32767; s = 1'b1; end
        if (a < -32768) begin a = -32768; s = 1'b1; end
        return {s, 16'(a)};
    endfunction

    task automatic model_update();
        elem_t e;
        logic [DW:0] r;
        if (!rst_ni) begin
            exp_q.delete();
            sat_exp = 1'b0;
            return;
        end
        if (exp_q.size() > 0 && z_ready_i) begin
            if (exp_q[0].sat) sat_exp = 1'b1;
            else if (clr_sat_i) sat_exp = 1'b0;
            void'(exp_q.pop_front());
        end else begin
            if (clr_sat_i) sat_exp = 1'b0;
            if (exp_q.size() == 0 && row_valid_i) begin
                for (int c = 0; c < NC; c++) begin
                    r      = requant(row_acc_i[c*AW +: AW], int'(shift_i));
                    e.z    = r[DW-1:0];
                    e.sat  = r[DW];
                    e.col  = c;
                    e.last = row_last_i && (c == NC - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic compare();
        bit v;
        v = (exp_q.size() > 0);
        chk("z_valid", 64'(z_valid_o), 64'(v));
        chk("row_ready", 64'(row_ready_o), 64'(!v));
        chk("sat", 64'(sat_o), 64'(sat_exp));
        if (v) begin
            chk("z", 64'(z_o), 64'(exp_q[0].z));
            chk("col_idx", 64'(col_idx_o), 64'(exp_q[0].col));
            chk("z_last", 64'(z_last_o), 64'(exp_q[0].last));
        end else begin
            chk("z_idle", 64'(z_o), 64'(0));
            chk("col_idle", 64'(col_idx_o), 64'(0));
            chk("last_idle", 64'(z_last_o), 64'(0));
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare();
    endtask

    task automatic set_row(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                           input int sh, input bit last);
        row_acc_i   = {a3, a2, a1, a0};
        shift_i     = SW'(sh);
        row_last_i  = last;
        row_valid_i = 1'b1;
    endtask

    function automatic logic [AW-1:0] rand_acc();
        logic [AW-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = AW'($signed(int'($urandom_range(0, 8191)) - 4096));
            2: v = $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: v = AW'($signed(int'($urandom_range(0, 65535)) - 32768)) <<
                         $urandom_range(0, 15);
        endcase
        return v;
    endfunction

    logic [DW:0] pin;

    initial begin
        n_chk = 0;
        n_pass = 0;
        sat_exp = 1'b0;

        // Model pins: hand-computed requantisation results
        pin = requant(32'h0000_0100, 8);   chk("pin_p100", 64'(pin), 64'({1'b0, 16'h0001}));
        pin = requant(32'hFFFF_FF00, 8);   chk("pin_m100", 64'(pin), 64'({1'b0, 16'hFFFF}));
        pin = requant(32'h7FFF_0000, 8);   chk("pin_satp", 64'(pin), 64'({1'b1, 16'h7FFF}));
        pin = requant(32'h8000_0000, 8);   chk("pin_satn", 64'(pin), 64'({1'b1, 16'h8000}));
        pin = requant(32'h7FFF_FFFF, 1);   chk("pin_max1", 64'(pin), 64'({1'b1, 16'h7FFF}));
        pin = requant(32'h0000_7FFF, 0);   chk("pin_sh0", 64'(pin), 64'({1'b0, 16'h7FFF}));
`ifdef REQUANT_ROUND_EN
        pin = requant(32'h0000_0180, 8);   chk("pin_p180", 64'(pin), 64'({1'b0, 16'h0002}));
        pin = requant(32'hFFFF_FE80, 8);   chk("pin_m180", 64'(pin), 64'({1'b0, 16'hFFFF}));
`else
        pin = requant(32'h0000_0180, 8);   chk("pin_p180", 64'(pin), 64'({1'b0, 16'h0001}));
        pin = requant(32'hFFFF_FE80, 8);   chk("pin_m180", 64'(pin), 64'({1'b0, 16'hFFFE}));
`endif

        // Reset
        step();
        step();
        rst_ni = 1'b1;
        step();

        // Row with in-range and saturating elements at full throughput
        z_ready_i = 1'b1;
        set_row(32'h0000_0100, 32'hFFFF_FF00, 32'h7FFF_0000, 32'h8000_0000, 8, 1'b0);
        step();
        row_valid_i = 1'b0;
        chk("t1_c0", 64'(z_o), 64'(16'h0001));
        step();
        chk("t1_c1", 64'(z_o), 64'(16'hFFFF));
        step();
        chk("t1_c2", 64'(z_o), 64'(16'h7FFF));
        chk("t1_sat_pre", 64'(sat_o), 64'(0));
        step();
        chk("t1_c3", 64'(z_o), 64'(16'h8000));
        chk("t1_sat", 64'(sat_o), 64'(1));
        step();
        chk("t1_idle", 64'(row_ready_o), 64'(1));

        // Backpressure at col 1 with a new row already offered
        set_row(rand_acc(), rand_acc(), rand_acc(), rand_acc(), 4, 1'b0);
        step();
        set_row(rand_acc(), rand_acc(), rand_acc(), rand_acc(), 12, 1'b1);
        step();
        z_ready_i = 1'b0;
        repeat (3) step();
        z_ready_i = 1'b1;
        repeat (4) step();
        row_valid_i = 1'b0;
        repeat (5) step();

        // Rounding behaviour pinned against the DUT
        set_row(32'h0000_0180, 32'hFFFF_FE80, 32'h7FFF_FFFF, 32'h0, 8, 1'b1);
        step();
        row_valid_i = 1'b0;
`ifdef REQUANT_ROUND_EN
        chk("t3_p180", 64'(z_o), 64'(16'h0002));
        step();
        chk("t3_m180", 64'(z_o), 64'(16'hFFFF));
`else
        chk("t3_p180", 64'(z_o), 64'(16'h0001));
        step();
        chk("t3_m180", 64'(z_o), 64'(16'hFFFE));
`endif
        repeat (3) step();
        set_row(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 1, 1'b0);
        step();
        row_valid_i = 1'b0;
        chk("t3_max_sh1", 64'(z_o), 64'(16'h7FFF));
        repeat (4) step();

        // Reset in the middle of a drain
        set_row(rand_acc(), rand_acc(), rand_acc(), rand_acc(), 0, 1'b1);
        step();
        row_valid_i = 1'b0;
        step();
        step();
        rst_ni = 1'b0;
        #1;
        chk("t5_valid", 64'(z_valid_o), 64'(0));
        chk("t5_sat", 64'(sat_o), 64'(0));
        exp_q.delete();
        sat_exp = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        set_row(32'h10, 32'h20, 32'h30, 32'h40, 0, 1'b0);
        step();
        row_valid_i = 1'b0;
        chk("t5_col0", 64'(col_idx_o), 64'(0));
        repeat (4) step();

        // Clear coinciding with a saturating accept, then clear alone
        set_row(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h0, 0, 1'b0);
        step();
        row_valid_i = 1'b0;
        step();
        clr_sat_i = 1'b1;
        step();
        chk("t6_set_wins", 64'(sat_o), 64'(1));
        clr_sat_i = 1'b0;
        repeat (3) step();
        clr_sat_i = 1'b1;
        step();
        chk("t6_clear", 64'(sat_o), 64'(0));
        clr_sat_i = 1'b0;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 1)
                set_row(rand_acc(), rand_acc(), rand_acc(), rand_acc(),
                        int'($urandom_range(0, AW - 1)), 1'($urandom_range(0, 1)));
            else
                row_valid_i = 1'b0;
            z_ready_i = ($urandom_range(0, 3) != 0);
            clr_sat_i = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
